psum_deskew_collector: RTL and testbench
========================================

Name: psum_deskew_collector

Overview:
- Sits at the output edge of the weight-stationary systolic array and consumes the per-column PSUM_OUT streams leaving the last PE row.
- The array emits results diagonally skewed: lane k of a result row arrives k cycles after lane 0.
- This block re-aligns each row, buffers it in a small FIFO, and presents whole rows on a valid/ready interface with row index and last-row flag.
- The array cannot stall, so buffer overflow is detected and flagged, never back-pressured.

Parameters:
- NUM_COL, 16, number of array output lanes (columns).
- PARTIAL_SUM_BW, 20, signed width of one lane's partial sum (16x16 array of 8b x 8b).
- FIFO_DEPTH, 4, aligned rows buffered; power of two, >= 2.
- ROW_CNT_BW, 8, width of the row index and tile_rows.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush; same effect as rst but sampled on clk.
- in_valid  in  1  lane 0 of a new result row is valid this cycle.
- psum_in  in  NUM_COL*PARTIAL_SUM_BW  skewed lane data; lane k occupies bits [k*BW +: BW].
- tile_rows  in  ROW_CNT_BW  rows per tile minus 1; sampled when the row index is 0 and a row is pushed.
- out_valid  out  1  aligned row available.
- out_ready  in  1  consumer accepts the row.
- out_data  out  NUM_COL*PARTIAL_SUM_BW  aligned row, same lane packing as psum_in.
- out_row  out  ROW_CNT_BW  row index within the tile of the head row.
- out_last  out  1  head row is the last row of its tile.
- ovf  out  1  sticky: a row was dropped because the FIFO was full.

Behaviour:
- Reset (rst async, or clr on an edge): all delay-line data and valid stages go to 0; FIFO becomes empty; write row counter goes to 0.
  - Output reset values: out_valid=0, out_data=0, out_row=0, out_last=0, ovf=0.
- Skew contract: a row with in_valid high at cycle t has lane k on psum_in at cycle t+k.
  - in_valid is not repeated for lanes 1..NUM_COL-1.
  - Back-to-back rows (in_valid every cycle) are legal.
- Deskew: lane k passes through NUM_COL-1-k registers. Lane NUM_COL-1 is direct.
  - A valid shift register of NUM_COL-1 stages tracks in_valid.
  - At cycle t+NUM_COL-1 the full row is aligned and a push is requested.
- Push: the row, write row index and last flag (index == captured tile_rows) enter the FIFO on the edge ending cycle t+NUM_COL-1.
  - out_valid rises at t+NUM_COL when the FIFO was empty, giving a fixed latency of NUM_COL cycles from in_valid to out_valid.
- Write row counter: increments per accepted push. On a push with last=1 it wraps to 0, and the next push recaptures tile_rows.
  - Dropped rows do not advance the counter.
- Pop: occurs when out_valid && out_ready.
  - out_data, out_row and out_last are the FIFO head, driven from registers or from memory with a registered read pointer.
  - They hold stable while out_valid=1 and out_ready=0.
- Full boundary: a push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle. Otherwise the row is dropped and ovf sets.
  - ovf clears only on rst or clr.
- Empty boundary: simultaneous push and pop on an empty FIFO is impossible, since out_valid=0. A push into an empty FIFO is visible the next cycle; there is no fall-through.
- Arithmetic: none. Data passes unmodified, sign preserved, no truncation.
- Mid-row reset or clr: partial rows in the delay lines are discarded. Lanes of that row arriving after reset are ignored because no valid is tracked for them.
- Counts: FIFO uses log2(FIFO_DEPTH)+1-bit pointers to distinguish full from empty.

Decomposition:
- Shared header sysarr_defs.vh holds the array-wide constants: NUM_COL/NUM_ROW, DATA_IN_BW, WEIGHT_BW, PARTIAL_SUM_BW.
  - The header also defines a lane-slice macro used by the array top and this block.
- One sub-module, psum_row_fifo.
  - Synchronous FIFO, width NUM_COL*PARTIAL_SUM_BW+ROW_CNT_BW+1, depth FIFO_DEPTH.
  - Ports push/pop/full/empty, async active-high rst, sync clr.
- Delay lines use the existing dff cell per stage, or a generate loop of registers.

Test Plan (bench uses NUM_COL=4, PARTIAL_SUM_BW=20, FIFO_DEPTH=4):
- Single row: in_valid at cycle 10; lanes 0..3 = 1, -2, 3, -4 at cycles 10..13; out_ready=1 -> out_valid only at cycle 14, out_data={-4,3,-2,1}, out_row=0, out_last=0 (tile_rows=3).
- Streaming: 8 consecutive rows, row r lane k = 100*r+k, out_ready=1, tile_rows=3 -> rows emerge in order one per cycle; out_row sequence 0,1,2,3,0,1,2,3; out_last high on rows 3 and 7; ovf=0.
- Back-pressure/overflow: out_ready=0, push 5 rows -> 4 buffered, 5th dropped, ovf=1. Then out_ready=1 -> rows 0..3 emerge intact with out_row 0..3; ovf stays 1.
- Full with simultaneous pop: FIFO full; out_ready=1 in the same cycle a 5th row is pushed -> no drop, ovf=0, all 5 rows delivered in order.
- Stall hold: out_ready toggles 0/1 every cycle -> out_data/out_row constant while out_valid && !out_ready; no duplicate or lost row.
- Reset mid-row: assert rst for 1 cycle at cycle t+2 of a row -> all outputs 0 immediately (async); the row never appears. The next clean row appears with out_row=0 at latency 4.

Source files
------------

// File: rtl/psum_deskew_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psum_deskew_collector_pkg
// Description : Array-wide constants for the weight-stationary systolic array
//               and a helper that locates a lane inside a packed row.
// Revision    : 1.0 - initial release
// ============================================================================
package psum_deskew_collector_pkg;

  // Array geometry and arithmetic widths shared by the array top and its edges.
  localparam int SA_NUM_COL        = 16;
  localparam int SA_NUM_ROW        = 16;
  localparam int SA_DATA_IN_BW     = 8;
  localparam int SA_WEIGHT_BW      = 8;
  localparam int SA_PARTIAL_SUM_BW = 20;

  // Collector defaults.
  localparam int PDC_FIFO_DEPTH    = 4;
  localparam int PDC_ROW_CNT_BW    = 8;

  // Lane k of a packed row starts at bit k*bw.
  function automatic int lane_lsb(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/psum_row_fifo.sv
`default_nettype none
// ============================================================================
// Module      : psum_row_fifo
// Description : Small synchronous FIFO for aligned partial-sum rows. The head
//               entry is read from memory through a registered read pointer,
//               so it holds stable until popped. Reads zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_row_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit separates the full and empty cases when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next-state for storage and pointers; a write into a full FIFO is only
  // allowed when the head leaves in the same cycle, freeing its slot.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // State registers with asynchronous reset and synchronous flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/psum_deskew_collector.sv
`default_nettype none
// ============================================================================
// Module      : psum_deskew_collector
// Description : Re-aligns the diagonally skewed PSUM_OUT lanes leaving the
//               systolic array, buffers whole rows, and presents them on a
//               valid/ready interface tagged with row index and last flag.
//               The array cannot stall: rows arriving at a full buffer are
//               dropped and flagged on a sticky overflow bit.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_deskew_collector
  import psum_deskew_collector_pkg::*;
#(
  parameter int NUM_COL        = SA_NUM_COL,
  parameter int PARTIAL_SUM_BW = SA_PARTIAL_SUM_BW,
  parameter int FIFO_DEPTH     = PDC_FIFO_DEPTH,
  parameter int ROW_CNT_BW     = PDC_ROW_CNT_BW
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              in_valid,
  input  logic [NUM_COL*PARTIAL_SUM_BW-1:0] psum_in,
  input  logic [ROW_CNT_BW-1:0]             tile_rows,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_COL*PARTIAL_SUM_BW-1:0] out_data,
  output logic [ROW_CNT_BW-1:0]             out_row,
  output logic                              out_last,
  output logic                              ovf
);

  localparam int ROW_W      = NUM_COL * PARTIAL_SUM_BW;
  localparam int ENTRY_W    = ROW_W + ROW_CNT_BW + 1;
  localparam int VLD_STAGES = NUM_COL - 1;

  logic [VLD_STAGES-1:0] vld_q, vld_d;
  logic [ROW_W-1:0]      row_aligned;
  logic [ROW_CNT_BW-1:0] wr_row_q, wr_row_d;
  logic [ROW_CNT_BW-1:0] tile_q, tile_d;
  logic                  ovf_q, ovf_d;

  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ROW_CNT_BW-1:0] eff_tile;
  logic                  row_last;
  logic [ENTRY_W-1:0]    fifo_rdata;

  // Per-lane delay lines: lane k waits NUM_COL-1-k cycles so every lane of a
  // row lines up with the last lane, which passes straight through.
  for (genvar k = 0; k < NUM_COL; k++) begin : g_lane
    localparam int LSB = lane_lsb(k, PARTIAL_SUM_BW);
    if (k == NUM_COL - 1) begin : g_direct
      assign row_aligned[LSB +: PARTIAL_SUM_BW] = psum_in[LSB +: PARTIAL_SUM_BW];
    end else begin : g_delay
      localparam int D = NUM_COL - 1 - k;
      logic [PARTIAL_SUM_BW-1:0] st_q [D];
      logic [PARTIAL_SUM_BW-1:0] st_d [D];

      // Shift the lane one stage per cycle.
      always_comb begin
        st_d[0] = psum_in[LSB +: PARTIAL_SUM_BW];
        for (int i = 1; i < D; i++) st_d[i] = st_q[i-1];
      end

      // Delay-line registers; a flush discards any partially collected row.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < D; i++) st_q[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < D; i++) st_q[i] <= '0;
        end else begin
          for (int i = 0; i < D; i++) st_q[i] <= st_d[i];
        end
      end

      assign row_aligned[LSB +: PARTIAL_SUM_BW] = st_q[D-1];
    end
  end

  assign push_req = vld_q[VLD_STAGES-1];
  assign pop      = out_valid && out_ready;

  // Track lane-0 valid through the skew, and decide push/drop and row tagging.
  always_comb begin
    vld_d[0] = in_valid;
    for (int i = 1; i < VLD_STAGES; i++) vld_d[i] = vld_q[i-1];

    // The tile length is taken live on the first row of a tile, then held.
    eff_tile = (wr_row_q == '0) ? tile_rows : tile_q;
    row_last = (wr_row_q == eff_tile);
    push_ok  = push_req && (!fifo_full || pop);

    wr_row_d = wr_row_q;
    tile_d   = tile_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      if (wr_row_q == '0) tile_d = tile_rows;
      wr_row_d = row_last ? '0 : wr_row_q + ROW_CNT_BW'(1);
    end
    if (push_req && !push_ok) ovf_d = 1'b1;
  end

  // Control registers with asynchronous reset and synchronous flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      wr_row_q <= '0;
      tile_q   <= '0;
      ovf_q    <= 1'b0;
    end else if (clr) begin
      vld_q    <= '0;
      wr_row_q <= '0;
      tile_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      wr_row_q <= wr_row_d;
      tile_q   <= tile_d;
      ovf_q    <= ovf_d;
    end
  end

  psum_row_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push_ok),
    .wdata ({row_aligned, wr_row_q, row_last}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata[ENTRY_W-1 -: ROW_W];
  assign out_row   = fifo_rdata[ROW_CNT_BW:1];
  assign out_last  = fifo_rdata[0];
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_deskew_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_deskew_collector
// Description : Randomized scoreboard bench for psum_deskew_collector with
//               NUM_COL=4, PARTIAL_SUM_BW=20, FIFO_DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_deskew_collector;

  localparam int NC  = 4;
  localparam int BW  = 20;
  localparam int FD  = 4;
  localparam int RBW = 8;
  localparam int RW  = NC * BW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clr = 1'b0;
  logic           in_valid = 1'b0;
  logic [RW-1:0]  psum_in = '0;
  logic [RBW-1:0] tile_rows = 8'd3;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [RW-1:0]  out_data;
  logic [RBW-1:0] out_row;
  logic           out_last;
  logic           ovf;

  psum_deskew_collector #(
    .NUM_COL        (NC),
    .PARTIAL_SUM_BW (BW),
    .FIFO_DEPTH     (FD),
    .ROW_CNT_BW     (RBW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .psum_in   (psum_in),
    .tile_rows (tile_rows),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0]  data;
    logic [RBW-1:0] row;
    logic           last;
  } exp_t;

  typedef struct {
    int            cyc;
    logic [RW-1:0] data;
  } pend_t;

  exp_t  sb[$];        // rows the model says are buffered, head first
  pend_t pending[$];   // rows issued by the driver, not yet aligned
  int    cyc = 0;
  int    wr_row = 0;
  int    tile_cap = 0;
  bit    ovf_exp = 1'b0;
  bit    m_last;
  pend_t m_p;

  int vectors = 0;
  int miscompares = 0;

  logic [RW-1:0] hist [NC];
  bit            hv   [NC];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a row issued in cycle c is complete NUM_COL-1 cycles
  // later and is then either queued or dropped. The monitor has already
  // removed any row popped in this cycle, so "room" is simply fewer than
  // FD rows left in the scoreboard.
  always @(posedge clk) begin
    if (rst || clr) begin
      sb.delete();
      pending.delete();
      wr_row   = 0;
      tile_cap = 0;
      ovf_exp  = 1'b0;
    end else if (pending.size() > 0 && pending[0].cyc + (NC - 1) == cyc) begin
      m_p = pending[0];
      pending.delete(0);
      if (sb.size() < FD) begin
        if (wr_row == 0) tile_cap = int'(tile_rows);
        m_last = (wr_row == tile_cap);
        sb.push_back('{m_p.data, RBW'(wr_row), m_last});
        wr_row = m_last ? 0 : wr_row + 1;
      end else begin
        ovf_exp = 1'b1;
      end
    end
    cyc++;
  end

  // Monitor: check presented rows against the scoreboard head mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", {127'd0, out_valid}, {127'd0, sb.size() > 0});
      if (out_valid && sb.size() > 0) begin
        chk("out_data", {48'd0, out_data}, {48'd0, sb[0].data});
        chk("out_row",  {120'd0, out_row}, {120'd0, sb[0].row});
        chk("out_last", {127'd0, out_last}, {127'd0, sb[0].last});
        if (out_ready) sb.delete(0);
      end
      chk("ovf", {127'd0, ovf}, {127'd0, ovf_exp});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [RW-1:0] mkrow(input int r);
    logic [RW-1:0] v;
    for (int k = 0; k < NC; k++) v[k*BW +: BW] = BW'(100 * r + k);
    return v;
  endfunction

  function automatic logic [RW-1:0] rndrow();
    logic [RW-1:0] v;
    for (int k = 0; k < NC; k++) v[k*BW +: BW] = BW'($urandom);
    return v;
  endfunction

  // One cycle of stimulus: lane k carries the row issued k cycles ago.
  task automatic step(input bit v, input logic [RW-1:0] row, input bit rdy,
                      input bit rs, input bit cl);
    @(posedge clk);
    #1;
    for (int k = NC - 1; k > 0; k--) begin
      hist[k] = hist[k-1];
      hv[k]   = hv[k-1];
    end
    hist[0] = row;
    hv[0]   = v;
    in_valid  = v;
    for (int k = 0; k < NC; k++)
      psum_in[k*BW +: BW] = hv[k] ? hist[k][k*BW +: BW] : BW'($urandom);
    out_ready = rdy;
    rst       = rs;
    clr       = cl;
    if (v && !rs && !cl) pending.push_back('{cyc, row});
    if (rs) begin
      #1;
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_out_data",  {48'd0, out_data},   128'd0);
      chk("rst_out_row",   {120'd0, out_row},   128'd0);
      chk("rst_out_last",  {127'd0, out_last},  128'd0);
      chk("rst_ovf",       {127'd0, ovf},       128'd0);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() > 0 || pending.size() > 0) && n < 60) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    idle(2, 1'b1);
    chk("drain_timeout", 128'(sb.size() + pending.size()), 128'd0);
  endtask

  task automatic do_clr();
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  logic [RW-1:0] single;

  initial begin
    for (int k = 0; k < NC; k++) begin
      hist[k] = '0;
      hv[k]   = 1'b0;
    end

    // Reset: outputs must be zero while held.
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Single signed row, tile_rows=3.
    tile_rows = 8'd3;
    single = {BW'(-4), BW'(3), BW'(-2), BW'(1)};
    step(1'b1, single, 1'b1, 1'b0, 1'b0);
    drain();

    // Streaming: 8 back-to-back rows across two tiles.
    do_clr();
    for (int r = 0; r < 8; r++) step(1'b1, mkrow(r), 1'b1, 1'b0, 1'b0);
    drain();

    // Overflow: consumer stalled, 5 rows, the 5th is dropped.
    do_clr();
    for (int r = 0; r < 5; r++) step(1'b1, mkrow(10 + r), 1'b0, 1'b0, 1'b0);
    idle(6, 1'b0);
    drain();
    idle(3, 1'b1);
    do_clr();

    // Full with a pop in the same cycle as the 5th push: nothing dropped.
    for (int r = 0; r < 4; r++) step(1'b1, mkrow(30 + r), 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b1, mkrow(34), 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drain();

    // Stall hold: ready toggles every cycle.
    do_clr();
    for (int r = 0; r < 6; r++) step(1'b1, mkrow(40 + r), r[0], 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, '0, i[0], 1'b0, 1'b0);
    drain();

    // Async reset in the middle of a row: that row never appears.
    do_clr();
    step(1'b1, mkrow(50), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    step(1'b1, mkrow(51), 1'b1, 1'b0, 1'b0);
    drain();

    // Random traffic with random back-pressure and tile lengths.
    for (int i = 0; i < 400; i++) begin
      tile_rows = 8'($urandom_range(0, 5));
      step(1'($urandom_range(0, 1)), rndrow(),
           ($urandom_range(0, 2) != 0), 1'b0, (i == 200));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
